// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / load-store) onto a single combinational-read RAM port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on ties; default is fixed priority (D over I).
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_is32,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_is32,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    logic   mem_we_q;
    logic   pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;  // port granted most recently; resets to D so I wins the first tie

    always_comb begin
        pick_d = d_req && (!i_req || !last_d);
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    // NOTE: the write strobe is gated by rst_n combinationally so a store caught in
    // ACCESS by reset never reaches the RAM at the edge where reset takes effect.
    assign mem_we = mem_we_q & rst_n;

    // The mem_* registers double as the latched request fields for the ACCESS cycle.
    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; the rdata registers are plain flops and are reset like the rest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            busy      <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_we_q  <= 1'b0;
            mem_is32  <= 1'b0;
            mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d    <= 1'b1;
`endif
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        d_gnt     <= pick_d;
                        i_gnt     <= !pick_d;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        mem_we_q  <= pick_d && d_we;
                        mem_is32  <= pick_d && d_is32;
                        mem_wdata <= pick_d ? d_wdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d    <= pick_d;
`endif
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    i_gnt <= 1'b0;
                    d_gnt <= 1'b0;
                    if (d_gnt) begin
                        d_rdata  <= mem_rdata;
                        d_rvalid <= 1'b1;
                    end else begin
                        i_rdata  <= mem_rdata;
                        i_rvalid <= 1'b1;
                    end
                    mem_addr  <= '0;
                    mem_we_q  <= 1'b0;
                    mem_is32  <= 1'b0;
                    mem_wdata <= '0;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
